// File: rtl/alu_ctrl_issue.sv
// Execute-stage issue register: decodes ALUOp/funct into the ALU control code
// and registers the operands behind a one-entry valid/ready pipeline slot.
module alu_ctrl_issue #(
    parameter int         DATA_W       = 32,
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic              alu_src,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] op_1,
    output logic [DATA_W-1:0] op_2,
    output logic [3:0]        alu_ctrl,
    output logic              ovf_trap_en,
    output logic              illegal_instr
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d;
    logic              ill_q, ill_d;
    logic              accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // funct is only looked at for R-type, so X on it cannot leak otherwise
    always_comb begin
        ctrl_d = 4'b0010;
        ovf_d  = 1'b0;
        ill_d  = 1'b0;
        unique case (alu_op)
            2'b00: ctrl_d = 4'b0010;
            2'b01: ctrl_d = 4'b0110;
            2'b11: ctrl_d = 4'b0001;
            2'b10: begin
                case (funct)
                    6'h20: begin
                        ctrl_d = 4'b0010;
                        ovf_d  = 1'b1;
                    end
                    6'h21: ctrl_d = 4'b0010;
                    6'h22: begin
                        ctrl_d = 4'b0110;
                        ovf_d  = 1'b1;
                    end
                    6'h23: ctrl_d = 4'b0110;
                    6'h24: ctrl_d = 4'b0000;
                    6'h25: ctrl_d = 4'b0001;
                    6'h27: ctrl_d = 4'b1100;
                    6'h2A: ctrl_d = 4'b0111;
                    default: begin
                        ctrl_d = ILLEGAL_CTRL;
                        ill_d  = 1'b1;
                    end
                endcase
            end
            default: ctrl_d = 4'b0010;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        if (!flush) begin
            valid_d = accept || (valid_q && !out_ready);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            ctrl_q  <= 4'b0000;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                op1_q  <= rs_data;
                op2_q  <= alu_src ? imm_ext : rt_data;
                ctrl_q <= ctrl_d;
                ovf_q  <= ovf_d;
                ill_q  <= ill_d;
            end
        end
    end

    assign out_valid     = valid_q;
    assign op_1          = op1_q;
    assign op_2          = op2_q;
    assign alu_ctrl      = ctrl_q;
    assign ovf_trap_en   = ovf_q;
    assign illegal_instr = ill_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue with hand-computed expectations.
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic        alu_src;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic [3:0]  alu_ctrl;
    logic        ovf_trap_en;
    logic        illegal_instr;

    int checks = 0;
    int errors = 0;

    alu_ctrl_issue dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_op(alu_op),
        .funct(funct),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .imm_ext(imm_ext),
        .alu_src(alu_src),
        .flush(flush),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .op_1(op_1),
        .op_2(op_2),
        .alu_ctrl(alu_ctrl),
        .ovf_trap_en(ovf_trap_en),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic v,
                           input logic [3:0] c, input logic o,
                           input logic il);
        chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, "_ctrl"}, {28'b0, alu_ctrl}, {28'b0, c});
        chk({tag, "_ovf"}, {31'b0, ovf_trap_en}, {31'b0, o});
        chk({tag, "_ill"}, {31'b0, illegal_instr}, {31'b0, il});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        funct     = 6'h00;
        rs_data   = '0;
        rt_data   = '0;
        imm_ext   = '0;
        alu_src   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        out_chk("rst", 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("rst_op1", op_1, 32'h0);
        chk("rst_op2", op_2, 32'h0);
        chk("rst_inrdy", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // R-type add, overflow trapping
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'h20;
        rs_data  = 32'h7FFF_FFFF;
        rt_data  = 32'h1;
        tick();
        out_chk("add", 1'b1, 4'b0010, 1'b1, 1'b0);
        chk("add_op1", op_1, 32'h7FFF_FFFF);
        chk("add_op2", op_2, 32'h1);

        funct = 6'h21;
        tick();
        out_chk("addu", 1'b1, 4'b0010, 1'b0, 1'b0);

        // lw with immediate, funct left unknown
        alu_op  = 2'b00;
        funct   = 6'bxxxxxx;
        alu_src = 1'b1;
        imm_ext = 32'hFFFF_FFFC;
        rs_data = 32'h100;
        tick();
        out_chk("lw", 1'b1, 4'b0010, 1'b0, 1'b0);
        chk("lw_op1", op_1, 32'h100);
        chk("lw_op2", op_2, 32'hFFFF_FFFC);

        alu_op  = 2'b01;
        alu_src = 1'b0;
        rt_data = 32'h5;
        tick();
        out_chk("beq", 1'b1, 4'b0110, 1'b0, 1'b0);
        chk("beq_op2", op_2, 32'h5);

        alu_op = 2'b11;
        tick();
        out_chk("ori", 1'b1, 4'b0001, 1'b0, 1'b0);

        in_valid = 1'b0;
        tick();
        out_chk("drain", 1'b0, 4'b0001, 1'b0, 1'b0);
        chk("drain_inrdy", {31'b0, in_ready}, 32'd1);

        // Backpressure: slt held while nor waits
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'h2A;
        rs_data  = 32'h3;
        rt_data  = 32'h9;
        tick();
        out_chk("slt", 1'b1, 4'b0111, 1'b0, 1'b0);
        out_ready = 1'b0;
        funct     = 6'h27;
        rs_data   = 32'hA;
        rt_data   = 32'hB;
        #1;
        chk("bp_inrdy0", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            out_chk("hold", 1'b1, 4'b0111, 1'b0, 1'b0);
            chk("hold_op1", op_1, 32'h3);
            chk("hold_inrdy", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("rel_inrdy", {31'b0, in_ready}, 32'd1);
        tick();
        out_chk("nor", 1'b1, 4'b1100, 1'b0, 1'b0);
        chk("nor_op1", op_1, 32'hA);
        chk("nor_op2", op_2, 32'hB);
        in_valid = 1'b0;
        tick();
        chk("nor_nodup", {31'b0, out_valid}, 32'd0);

        // Flush drops both held and incoming
        in_valid = 1'b1;
        funct    = 6'h24;
        rs_data  = 32'h1;
        tick();
        out_chk("and", 1'b1, 4'b0000, 1'b0, 1'b0);
        funct     = 6'h22;
        rs_data   = 32'h55;
        flush     = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush_gone", {31'b0, out_valid}, 32'd0);

        // Illegal funct, then back-to-back recovery
        in_valid = 1'b1;
        funct    = 6'h26;
        tick();
        out_chk("ill", 1'b1, 4'b1111, 1'b0, 1'b1);
        funct = 6'h24;
        tick();
        out_chk("ill_and", 1'b1, 4'b0000, 1'b0, 1'b0);
        funct = 6'h22;
        tick();
        out_chk("sub", 1'b1, 4'b0110, 1'b1, 1'b0);
        funct = 6'h23;
        tick();
        out_chk("subu", 1'b1, 4'b0110, 1'b0, 1'b0);
        funct = 6'h25;
        tick();
        out_chk("or", 1'b1, 4'b0001, 1'b0, 1'b0);

        // Async reset in the middle of a hold
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        out_chk("arst", 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("arst_inrdy", {31'b0, in_ready}, 32'd1);
        chk("arst_op1", op_1, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Execute-stage issue register that drives the combinational ALU.
- Decodes the main-control ALUOp and the R-type funct field into the 4-bit ALU control code, and selects and registers op_1/op_2.
- Flags instructions whose overflow must raise an exception, and flags unsupported funct codes.
- Sits between the decode stage and the ALU; one-entry pipeline register with valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 32, operand width; ALU is fixed at 32.
- ILLEGAL_CTRL, 4'b1111, alu_ctrl value issued for an unsupported funct; the ALU returns 0 for it.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode stage presents an instruction
- in_ready  output  1  issuer can accept this cycle
- alu_op  input  2  main-control ALUOp: 00 add (lw/sw/addi), 01 sub (beq), 10 R-type per funct, 11 or (ori)
- funct  input  6  instruction funct field, used only when alu_op=10
- rs_data  input  DATA_W  register-file read port 1
- rt_data  input  DATA_W  register-file read port 2
- imm_ext  input  DATA_W  immediate, already sign/zero-extended upstream
- alu_src  input  1  1: op_2 = imm_ext, 0: op_2 = rt_data
- flush  input  1  discard held and incoming instruction (branch/exception)
- out_ready  input  1  downstream accepts the issued operation
- out_valid  output  1  op_1/op_2/alu_ctrl are valid
- op_1  output  DATA_W  to ALU op_1
- op_2  output  DATA_W  to ALU op_2
- alu_ctrl  output  4  to ALU alu_ctrl
- ovf_trap_en  output  1  ALU overflow output must raise an exception for this op
- illegal_instr  output  1  unsupported funct; qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): out_valid=0, op_1=0, op_2=0, alu_ctrl=4'b0000, ovf_trap_en=0, illegal_instr=0. Deassertion is synchronised externally.
- in_ready = !out_valid || out_ready. Combinational; no dependence on in_valid.
- Accept when in_valid && in_ready && !flush. At the next clk edge, register the decoded fields and set out_valid=1. Latency from in to out is 1 cycle; throughput is 1 per cycle.
- Hold when out_valid && !out_ready: all outputs stable, in_ready=0, inputs ignored.
- Drain when out_valid && out_ready && !(in_valid && !flush): out_valid becomes 0. Data registers keep their last value.
- Flush has priority over everything: next cycle out_valid=0 and the incoming instruction is dropped. Data registers may keep stale values.
- op_1 = rs_data. op_2 = alu_src ? imm_ext : rt_data.
- Decode for alu_op 00, 01 and 11. illegal_instr=0 in all three cases.
  - 00 -> 0010, ovf_trap_en=0.
  - 01 -> 0110, ovf_trap_en=0.
  - 11 -> 0001, ovf_trap_en=0.
- Decode for alu_op 10 (funct). ovf_trap_en=0 unless stated; illegal_instr=0 unless stated.
  - 0x20 add -> 0010, ovf_trap_en=1.
  - 0x21 addu -> 0010.
  - 0x22 sub -> 0110, ovf_trap_en=1.
  - 0x23 subu -> 0110.
  - 0x24 and -> 0000.
  - 0x25 or -> 0001.
  - 0x27 nor -> 1100.
  - 0x2A slt -> 0111.
  - Any other funct -> ILLEGAL_CTRL, illegal_instr=1.
- funct is a don't-care for alu_op≠10. X on funct must not propagate in that case.
- Reset mid-hold clears out_valid immediately (asynchronously); the held instruction is lost.
- The flag outputs (ovf_trap_en, illegal_instr) are registered with the data and valid only while out_valid=1.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0 and alu_ctrl=0000 before the next edge; in_ready=1.
- R-type add: alu_op=10, funct=0x20, rs=0x7FFFFFFF, rt=1, alu_src=0, out_ready=1 -> 1 cycle later op_1=0x7FFFFFFF, op_2=1, alu_ctrl=0010, ovf_trap_en=1. Repeat with funct=0x21 -> ovf_trap_en=0.
- lw with immediate: alu_op=00, alu_src=1, imm_ext=0xFFFFFFFC, rs=0x100 -> op_2=0xFFFFFFFC, alu_ctrl=0010. beq: alu_op=01 -> alu_ctrl=0110.
- Backpressure: issue slt (funct 0x2A) then hold out_ready=0 for 3 cycles while in_valid=1 with nor -> in_ready=0, outputs stay slt/0111. Release -> nor/1100 issued the next cycle, no loss or duplicate.
- Flush: out_valid=1 and in_valid=1 with flush=1 for one cycle -> next cycle out_valid=0; the dropped instruction never appears.
- Illegal: alu_op=10, funct=0x26 -> alu_ctrl=1111, illegal_instr=1, out_valid=1. Back-to-back with funct=0x24 -> illegal_instr returns to 0, alu_ctrl=0000.
